// File: rtl/tree_vc_route_queue.sv
// Tree-router route stage: computes the nearest-common-ancestor output port of each head flit
// and queues it per VC until that packet's tail flit leaves the input buffer.
module tree_vc_route_queue #(
    parameter int K = 2,
    parameter int L = 2,
    parameter int V = 2,
    parameter int R = 2,
    localparam int KW   = (K <= 2) ? 1 : $clog2(K),
    localparam int LKW  = L * KW,
    localparam int LW   = (L <= 2) ? 1 : $clog2(L),
    localparam int DSPW = $clog2(K + 1),
    localparam int CW   = $clog2(R + 1),
    localparam int PW   = (R <= 2) ? 1 : $clog2(R),
    localparam int OHW  = K + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LKW-1:0]    current_addr_encoded_i,
    input  logic [LW-1:0]     current_level_i,
    input  logic              hdr_wr_i,
    input  logic [V-1:0]      hdr_vc_i,
    input  logic [LKW-1:0]    dest_addr_encoded_i,
    input  logic              rd_i,
    input  logic [V-1:0]      rd_vc_i,
    input  logic              rd_is_tail_i,
    output logic [V-1:0]      route_valid_o,
    output logic [V*DSPW-1:0] destport_o,
    output logic [V*OHW-1:0]  destport_onehot_o,
    output logic [V-1:0]      ovf_err_o,
    output logic [V-1:0]      unf_err_o
);

    logic              w_up;
    logic [KW-1:0]     w_down_digit;
    logic [DSPW-1:0]   w_port;
    logic              w_unused_addr;

    logic [V-1:0]      w_push, w_pop_req, w_do_push, w_do_pop, w_full, w_empty;

    logic [PW-1:0]     r_wr_ptr [V];
    logic [PW-1:0]     r_rd_ptr [V];
    logic [CW-1:0]     r_count  [V];
    logic [DSPW-1:0]   r_mem    [V][R];
    logic [V-1:0]      r_ovf, r_unf;

    // Only digits 0..L-2 of our own address take part in the ancestor comparison.
    assign w_unused_addr = ^current_addr_encoded_i[LKW-1 -: KW];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can hold an old value and infer a latch.
        w_up         = 1'b0;
        w_down_digit = '0;
        for (int i = 1; i < L; i++) begin
            if ((int'(current_level_i) < i) &&
                (current_addr_encoded_i[(i-1)*KW +: KW] != dest_addr_encoded_i[i*KW +: KW]))
                w_up = 1'b1;
        end
        for (int j = 0; j < L; j++) begin
            if (int'(current_level_i) == j)
                w_down_digit = dest_addr_encoded_i[j*KW +: KW];
        end
        w_port = w_up ? DSPW'(K) : DSPW'(w_down_digit);
    end

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(R - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_push    = '0;
        w_pop_req = '0;
        w_empty   = '0;
        w_full    = '0;
        w_do_pop  = '0;
        w_do_push = '0;
        for (int v = 0; v < V; v++) begin
            w_push[v]    = hdr_wr_i & hdr_vc_i[v];
            w_pop_req[v] = rd_i & rd_is_tail_i & rd_vc_i[v];
            w_empty[v]   = (r_count[v] == '0);
            w_full[v]    = (r_count[v] == CW'(R));
            w_do_pop[v]  = w_pop_req[v] & ~w_empty[v];
            // A full FIFO still accepts a push when the same edge frees a slot.
            w_do_push[v] = w_push[v] & (~w_full[v] | w_do_pop[v]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so each flop samples pre-edge values regardless of statement order.
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
            r_ovf <= '0;
            r_unf <= '0;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (w_do_push[v]) r_wr_ptr[v] <= ptr_next(r_wr_ptr[v]);
                if (w_do_pop[v])  r_rd_ptr[v] <= ptr_next(r_rd_ptr[v]);
                if (w_do_push[v] && !w_do_pop[v])
                    r_count[v] <= r_count[v] + CW'(1);
                else if (!w_do_push[v] && w_do_pop[v])
                    r_count[v] <= r_count[v] - CW'(1);
                if (w_push[v] && !w_do_push[v]) r_ovf[v] <= 1'b1;
                if (w_pop_req[v] && w_empty[v]) r_unf[v] <= 1'b1;
            end
        end
    end

    // NOTE: route storage has no reset; r_count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        for (int v = 0; v < V; v++) begin
            if (!reset && w_do_push[v])
                r_mem[v][r_wr_ptr[v]] <= w_port;
        end
    end

    always_comb begin
        route_valid_o     = '0;
        destport_o        = '0;
        destport_onehot_o = '0;
        for (int v = 0; v < V; v++) begin
            if (!w_empty[v]) begin
                route_valid_o[v]                 = 1'b1;
                destport_o[v*DSPW +: DSPW]       = r_mem[v][r_rd_ptr[v]];
                destport_onehot_o[v*OHW +: OHW]  = OHW'(1) << r_mem[v][r_rd_ptr[v]];
            end
        end
    end

    assign ovf_err_o = r_ovf;
    assign unf_err_o = r_unf;

endmodule
